// File: rtl/tap_accumulator.sv
// Sums NUM_TAPS signed fixed-point product samples per frame, then floor-shifts
// the total to the output format and saturates it, flagging overflow.
module tap_accumulator #(
   parameter int DIN_WIDTH  = 32,
   parameter int DIN_FRAC   = 28,
   parameter int DOUT_WIDTH = 16,
   parameter int DOUT_FRAC  = 14,
   parameter int NUM_TAPS   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_valid,
   input  logic [DIN_WIDTH-1:0]         i_data,
   input  logic                         i_ovr,
   input  logic                         i_clear,
   output logic                         o_valid,
   output logic signed [DOUT_WIDTH-1:0] o_result,
   output logic                         o_ovr
);

   localparam int CNT_W = $clog2(NUM_TAPS);
   localparam int ACC_W = DIN_WIDTH + CNT_W;
   localparam int SHIFT = DIN_FRAC - DOUT_FRAC;
   localparam int EXT_W = ((ACC_W > DOUT_WIDTH) ? ACC_W : DOUT_WIDTH) + 1;

   localparam logic signed [EXT_W-1:0] SAT_MAX =
      {{(EXT_W-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] SAT_MIN =
      {{(EXT_W-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t                         state_q;
   logic [CNT_W-1:0]               count_q;
   logic signed [ACC_W-1:0]        acc_q;
   logic                           flag_q;
   logic                           valid_q;
   logic signed [DOUT_WIDTH-1:0]   result_q;
   logic                           ovr_q;

   logic                           last_d;
   logic signed [ACC_W-1:0]        data_ext_d;
   logic signed [ACC_W-1:0]        sum_d;
   logic signed [ACC_W-1:0]        shifted_d;
   logic signed [EXT_W-1:0]        shifted_ext_d;
   logic signed [DOUT_WIDTH-1:0]   result_d;
   logic                           sat_d;
   logic                           flag_d;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      last_d        = 1'b0;
      data_ext_d    = {{CNT_W{i_data[DIN_WIDTH-1]}}, i_data};
      sum_d         = acc_q + data_ext_d;
      flag_d        = flag_q | i_ovr;
      shifted_d     = sum_d >>> SHIFT;
      shifted_ext_d = {{(EXT_W-ACC_W){shifted_d[ACC_W-1]}}, shifted_d};
      result_d      = shifted_ext_d[DOUT_WIDTH-1:0];
      sat_d         = 1'b0;
      if (i_valid && !i_clear && state_q == ACCUM && count_q == CNT_W'(NUM_TAPS-1)) begin
         last_d = 1'b1;
      end
      if (shifted_ext_d > SAT_MAX) begin
         result_d = SAT_MAX[DOUT_WIDTH-1:0];
         sat_d    = 1'b1;
      end else if (shifted_ext_d < SAT_MIN) begin
         result_d = SAT_MIN[DOUT_WIDTH-1:0];
         sat_d    = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         acc_q    <= '0;
         flag_q   <= 1'b0;
         valid_q  <= 1'b0;
         result_q <= '0;
         ovr_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (i_clear) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            flag_q  <= 1'b0;
         end else if (i_valid) begin
            if (state_q == IDLE) begin
               state_q <= ACCUM;
               count_q <= CNT_W'(1);
               acc_q   <= data_ext_d;
               flag_q  <= i_ovr;
            end else if (last_d) begin
               // Frame complete: publish the converted sum and free the datapath for the next frame.
               valid_q  <= 1'b1;
               result_q <= result_d;
               ovr_q    <= flag_d | sat_d;
               state_q  <= IDLE;
               count_q  <= '0;
               acc_q    <= '0;
               flag_q   <= 1'b0;
            end else begin
               count_q <= count_q + CNT_W'(1);
               acc_q   <= sum_d;
               flag_q  <= flag_d;
            end
         end
      end
   end

   assign o_valid  = valid_q;
   assign o_result = result_q;
   assign o_ovr    = ovr_q;

endmodule
